rggen_apb_host_bridge: RTL
==========================

RGGEN_APB_HOST_BRIDGE -- requirements
Module: rggen_apb_host_bridge

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16: APB paddr width.
REQ-002 SHALL have parameter LOCAL_ADDRESS_WIDTH, default 16, at most ADDRESS_WIDTH: register-block address span.
REQ-003 SHALL have parameter BUS_WIDTH, default 32, legal values 32 or 64: data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 0: abort limit in cycles; 0 disables the timeout.
REQ-005 SHALL have parameter USE_PSTRB, default 1: 0 means an APB3 master with no pstrb.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port apb_if, rggen_apb_if.slave: psel, penable, paddr[ADDRESS_WIDTH], pwrite, pwdata/prdata[BUS_WIDTH], pstrb[BUS_WIDTH/8], pready, pslverr.
REQ-009 SHALL have port bus_if, rggen_bus_if.master: request, address[LOCAL_ADDRESS_WIDTH], direction, write_data, write_strobe, done, read_data, status[2].

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, RESPOND.
REQ-011 IDLE: when psel=1, SHALL capture paddr/pwrite/pwdata/strobe, then go to BUSY, or to RESPOND if the address is out of range (REQ-016).
REQ-012 BUSY: SHALL drive bus_if.request=1 from captured registers; SHALL hold address, direction, write_data and write_strobe stable until exit.
REQ-013 BUSY: on done=1, SHALL register read_data and status[1] into response registers, then go to RESPOND.
REQ-014 RESPOND: SHALL drive pready=1 for exactly one cycle with the registered prdata/pslverr, then return to IDLE.
REQ-015 Latency SHALL be pready 1 cycle after done, and request 1 cycle after psel is first sampled; minimum APB transfer is 3 cycles.
REQ-016 paddr bits [ADDRESS_WIDTH-1:LOCAL_ADDRESS_WIDTH] nonzero SHALL skip BUSY, never assert request, and respond with pslverr=1, prdata=0.
REQ-017 bus_if.address SHALL be paddr with the low log2(BUS_WIDTH/8) bits forced to 0.
REQ-018 write_strobe SHALL be pstrb when USE_PSTRB=1 and pwrite=1, all ones when USE_PSTRB=0 and pwrite=1, and all zeros for reads.
REQ-019 When TIMEOUT_CYCLES>0, a cycle counter SHALL run in BUSY; done absent for TIMEOUT_CYCLES cycles SHALL deassert request and go to RESPOND with pslverr=1, prdata=0.
REQ-020 done and timeout expiry in the same cycle SHALL be resolved as done; the counter SHALL clear on BUSY entry.
REQ-021 psel falling while in BUSY (a protocol violation) SHALL NOT abort; the bus access SHALL complete and the response SHALL still be presented.
REQ-022 pready, pslverr and prdata SHALL be 0 outside RESPOND; request SHALL be 0 outside BUSY.
REQ-023 Back-to-back transfers SHALL pass through one IDLE cycle; a psel sampled in IDLE starts the next access.

Reset
REQ-024 rst_n=0 SHALL immediately force the FSM to IDLE and clear all capture, response and counter registers.
REQ-025 Reset SHALL force request, pready, pslverr and prdata to 0, including mid-BUSY, with no completion response.

Structure
REQ-026 rggen_rtl_pkg SHALL hold rggen_direction, the bus status enum (OKAY, EXOKAY, SLAVE_ERROR, DECODE_ERROR; bit1 = error) and the FSM state typedef.
REQ-027 The timeout counter SHALL be a sub-module, rggen_timeout_counter (parameter LIMIT; ports clk, rst_n, clear, enable, expired), omitted by generate when TIMEOUT_CYCLES=0.

Verification
REQ-028 Write, 0x0010, pwdata 0xA5A5_0001, pstrb 0x3, done on cycle 2 of BUSY -> request 2 cycles, write_strobe 0x3, pready 1 cycle later, pslverr=0.
REQ-029 Read, 0x0004, read_data 0x1234_5678, status OKAY -> prdata 0x1234_5678, pslverr=0, pready a single cycle.
REQ-030 ADDRESS_WIDTH=20, LOCAL_ADDRESS_WIDTH=16, paddr 0x1_0000 -> request never asserted, pslverr=1, prdata=0, pready at cycle 2.
REQ-031 TIMEOUT_CYCLES=8, done withheld -> request drops after 8 BUSY cycles, pslverr=1; done arriving on cycle 8 -> normal response instead.
REQ-032 USE_PSTRB=0, write -> write_strobe 0xF; read -> 0x0; BUS_WIDTH=64, paddr 0x000C -> address 0x0008.
REQ-033 rst_n low in BUSY cycle 3 -> request and pready 0 asynchronously; after release, the next psel starts a clean access.

Source files
------------

// File: rtl/rggen_apb_host_bridge_pkg.sv
// +----------------------------------------------------------------------+
// | rggen_rtl_pkg : shared types for the APB host bridge                  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  // Bit 1 of the status code flags an error response.
  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESPOND = 2'd2
  } rggen_bridge_state;

endpackage

`default_nettype wire

// File: rtl/rggen_apb_host_bridge_if.sv
// +----------------------------------------------------------------------+
// | rggen_apb_if / rggen_bus_if : APB slave side and register-bus side    |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface rggen_apb_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  logic                     psel;
  logic                     penable;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic                     pwrite;
  logic [BUS_WIDTH-1:0]     pwdata;
  logic [BUS_WIDTH/8-1:0]   pstrb;
  logic                     pready;
  logic [BUS_WIDTH-1:0]     prdata;
  logic                     pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

interface rggen_bus_if
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  logic                     request;
  logic [ADDRESS_WIDTH-1:0] address;
  rggen_direction           direction;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH/8-1:0]   write_strobe;
  logic                     done;
  logic [BUS_WIDTH-1:0]     read_data;
  logic [1:0]               status;

  modport master (
    output request, address, direction, write_data, write_strobe,
    input  done, read_data, status
  );

  modport slave (
    input  request, address, direction, write_data, write_strobe,
    output done, read_data, status
  );
endinterface

`default_nettype wire

// File: rtl/rggen_timeout_counter.sv
// +----------------------------------------------------------------------+
// | rggen_timeout_counter : flags the LIMIT-th consecutive enabled cycle  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rggen_timeout_counter #(
  parameter int LIMIT = 8
)(
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clear,
  input  wire logic enable,
  output logic      expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Count k-1 is held during the k-th enabled cycle.
  assign expired = enable && (r_count == CW'(LIMIT - 1));
endmodule

`default_nettype wire

// File: rtl/rggen_apb_host_bridge.sv
// +----------------------------------------------------------------------+
// | rggen_apb_host_bridge : APB slave to register-bus host bridge         |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rggen_apb_host_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH       = 16,
  parameter int LOCAL_ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH           = 32,
  parameter int TIMEOUT_CYCLES      = 0,
  parameter int USE_PSTRB           = 1
)(
  input  wire logic   clk,
  input  wire logic   rst_n,
  rggen_apb_if.slave  apb_if,
  rggen_bus_if.master bus_if
);
  localparam int STRB_WIDTH = BUS_WIDTH / 8;
  localparam int ALIGN_BITS = $clog2(STRB_WIDTH);
  localparam logic [LOCAL_ADDRESS_WIDTH-1:0] ALIGN_MASK =
    LOCAL_ADDRESS_WIDTH'((1 << ALIGN_BITS) - 1);

  rggen_bridge_state              r_state;
  rggen_bridge_state              w_next;
  logic                           w_start;
  logic                           w_out_of_range;
  logic                           w_timeout;
  logic [STRB_WIDTH-1:0]          w_strobe;
  logic [LOCAL_ADDRESS_WIDTH-1:0] r_addr;
  rggen_direction                 r_dir;
  logic [BUS_WIDTH-1:0]           r_wdata;
  logic [STRB_WIDTH-1:0]          r_strobe;
  logic [BUS_WIDTH-1:0]           r_rdata;
  logic                           r_slverr;

  wire w_unused = &{1'b0, apb_if.penable, apb_if.pstrb, bus_if.status[0]};

  if (ADDRESS_WIDTH > LOCAL_ADDRESS_WIDTH) begin : g_range_check
    assign w_out_of_range = |apb_if.paddr[ADDRESS_WIDTH-1:LOCAL_ADDRESS_WIDTH];
  end else begin : g_full_range
    assign w_out_of_range = 1'b0;
  end

  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    rggen_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (w_start),
      .enable  (r_state == ST_BUSY),
      .expired (w_timeout)
    );
  end else begin : g_no_timeout
    assign w_timeout = 1'b0;
  end

  always_comb begin
    w_strobe = '0;
    if (apb_if.pwrite) begin
      w_strobe = (USE_PSTRB != 0) ? apb_if.pstrb : '1;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (apb_if.psel) begin
          w_start = 1'b1;
          w_next  = w_out_of_range ? ST_RESPOND : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus_if.done || w_timeout) begin
          w_next = ST_RESPOND;
        end
      end
      ST_RESPOND: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_dir    <= RGGEN_READ;
      r_wdata  <= '0;
      r_strobe <= '0;
    end else if (w_start) begin
      r_addr   <= apb_if.paddr[LOCAL_ADDRESS_WIDTH-1:0] & ~ALIGN_MASK;
      r_dir    <= apb_if.pwrite ? RGGEN_WRITE : RGGEN_READ;
      r_wdata  <= apb_if.pwdata;
      r_strobe <= w_strobe;
    end
  end

  // done wins over a timeout expiring in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_slverr <= 1'b0;
    end else if (w_start) begin
      r_rdata  <= '0;
      r_slverr <= w_out_of_range;
    end else if (r_state == ST_BUSY) begin
      if (bus_if.done) begin
        r_rdata  <= bus_if.read_data;
        r_slverr <= bus_if.status[1];
      end else if (w_timeout) begin
        r_rdata  <= '0;
        r_slverr <= 1'b1;
      end
    end
  end

  assign bus_if.request      = (r_state == ST_BUSY);
  assign bus_if.address      = r_addr;
  assign bus_if.direction    = r_dir;
  assign bus_if.write_data   = r_wdata;
  assign bus_if.write_strobe = r_strobe;

  assign apb_if.pready  = (r_state == ST_RESPOND);
  assign apb_if.prdata  = (r_state == ST_RESPOND) ? r_rdata : '0;
  assign apb_if.pslverr = (r_state == ST_RESPOND) && r_slverr;
endmodule

`default_nettype wire
